capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//  Sequences one acquisition from the trigger/transition detector into a circular sample RAM.
//  Run-length encodes samples into packets and tracks pre- and post-trigger depth.
//  Reports completion, then walks the RAM oldest-first for host readout via trace registers.
//  Sits between the analyzer control FSM/trigger detector and the sample memory.
// PARAMETERS
//  SAMPLE_WIDTH  8   sample channels per packet
//  ADDR_WIDTH    10  RAM address bits; depth = 2**ADDR_WIDTH packets
//  PACKET_WIDTH  16  must equal SAMPLE_WIDTH+8; packet = {trig_flag, run_len[6:0], sample}
// PORTS
//  clk           in   1     clock
//  reset         in   1     synchronous, active-high
//  start         in   1     level; a rising edge starts capture
//  abort         in   1     level; while high, forces IDLE
//  pre_depth     in   ADDR  packets of history required before a trigger is accepted
//  post_depth    in   ADDR  packets to write after the trigger packet
//  latest_sample in   SW    current registered sample
//  transition    in   1     latest_sample != previous sample
//  triggered     in   1     trigger condition met this cycle
//  mem_we        out  1     RAM write strobe
//  mem_waddr     out  ADDR  RAM write address
//  mem_wdata     out  PW    RAM write data
//  rd_next       in   1     host pulse: advance readout by one packet
//  rd_addr       out  ADDR  RAM read address for readout
//  rd_last       out  1     rd_addr is the final valid packet
//  idle/running/post_trig/complete  out 1 each  one-hot state flags
//  wrapped       out  1     wr_ptr has wrapped at least once this capture
//  trig_addr     out  ADDR  address of the trigger packet
// BEHAVIOUR
//  Reset: state IDLE; idle=1, all other flags 0; mem_we=0; all pointers, counters and addresses 0.
//  States: IDLE -> PRE -> POST -> DONE; DONE -> PRE on a start edge; any state -> IDLE on abort.
//  Priority: reset > abort > start edge > triggered. Start edges in PRE/POST are ignored.
//  Enter PRE: clear wr_ptr, pkt_cnt, run_len and wrapped.
//    First PRE cycle always writes {1'b0, 7'd0, latest_sample}.
//  Each PRE/POST cycle with no write: run_len += 1.
//    A write occurs when transition=1 or run_len=127.
//    Write data is {trig_flag, run_len, latest_sample}; run_len then clears to 0.
//  Write: mem_we=1 for 1 cycle; mem_waddr=wr_ptr; then wr_ptr+1, wrapping at 2**ADDR_WIDTH to 0.
//    Wrapping sets wrapped. mem_we/waddr/wdata are registered, 1 cycle after the deciding cycle.
//  PRE: pkt_cnt counts writes and saturates at 2**ADDR_WIDTH-1.
//    triggered is ignored while pkt_cnt < pre_depth.
//    An accepted trigger forces a write that cycle with trig_flag=1, latches trig_addr=wr_ptr,
//    clears post_cnt, then goes to POST.
//  POST: post_cnt counts writes excluding the trigger packet; further triggers are ignored.
//    Go to DONE after the write where post_cnt reaches post_depth. post_depth=0 -> DONE right after the trigger write.
//    Also go to DONE when the next wr_ptr would equal trig_addr (buffer full, trigger packet kept).
//  DONE: no writes; complete=1.
//    rd_addr starts at oldest = wrapped ? wr_ptr : 0.
//    rd_next advances rd_addr (with wrap); it is ignored once rd_last=1.
//    rd_last=1 when rd_addr == wr_ptr-1 (mod depth).
//  Outside DONE, rd_next has no effect and rd_addr holds 0.
//  Abort mid-write: the in-flight registered write completes; no further writes.
// TESTING
//  1 Reset, start edge, sample constant 0x00 for 300 cycles -> packets 0,127,127 with sample 0x00; running=1.
//  2 pre_depth=4, post_depth=3, transitions every cycle, trigger on cycle 2 then cycle 6
//    -> first ignored; trigger packet has bit15=1; 3 more packets; then complete=1.
//  3 ADDR_WIDTH=4, pre_depth=2, 20 transitions before trigger -> wrapped=1; readout starts at wr_ptr;
//    16 rd_next pulses visit 16 addresses; rd_last on the 16th.
//  4 post_depth=0x3FF with small ADDR -> DONE when buffer fills; trig_addr packet not overwritten.
//  5 abort during POST with triggered and start edge in the same cycle -> idle=1 next cycle; no more mem_we.
//  6 reset asserted in POST -> all outputs at reset values next cycle; new start edge captures normally.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// Bus between the capture sequencer, its trigger/transition source, the sample RAM and the host readout.
// master is the sequencer side; slave is the environment that drives the controls.
interface capture_sequencer_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int PACKET_WIDTH = 16
);
    logic                    start;
    logic                    abort;
    logic [ADDR_WIDTH-1:0]   pre_depth;
    logic [ADDR_WIDTH-1:0]   post_depth;
    logic [SAMPLE_WIDTH-1:0] latest_sample;
    logic                    transition;
    logic                    triggered;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [PACKET_WIDTH-1:0] mem_wdata;
    logic                    rd_next;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_last;
    logic                    idle;
    logic                    running;
    logic                    post_trig;
    logic                    complete;
    logic                    wrapped;
    logic [ADDR_WIDTH-1:0]   trig_addr;

    modport master (
        input  start, abort, pre_depth, post_depth, latest_sample, transition, triggered, rd_next,
        output mem_we, mem_waddr, mem_wdata, rd_addr, rd_last,
        output idle, running, post_trig, complete, wrapped, trig_addr
    );

    modport slave (
        output start, abort, pre_depth, post_depth, latest_sample, transition, triggered, rd_next,
        input  mem_we, mem_waddr, mem_wdata, rd_addr, rd_last,
        input  idle, running, post_trig, complete, wrapped, trig_addr
    );
endinterface

// File: rtl/capture_sequencer.sv
// Sequences one run-length-encoded acquisition into a circular sample RAM, then walks the
// stored packets oldest-first for host readout.
module capture_sequencer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int PACKET_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    capture_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [6:0]            RUN_MAX   = 7'd127;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    start_q_r;
    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic [ADDR_WIDTH-1:0]   pkt_cnt_r;
    logic [ADDR_WIDTH-1:0]   post_cnt_r;
    logic [ADDR_WIDTH-1:0]   trig_addr_r;
    logic [6:0]              run_len_r;
    logic                    wrapped_r;
    logic                    first_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_waddr_r;
    logic [PACKET_WIDTH-1:0] mem_wdata_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic                    rd_last_r;
    logic                    idle_r;
    logic                    running_r;
    logic                    post_trig_r;
    logic                    complete_r;

    logic                    start_edge_s;
    logic                    write_s;
    logic                    accept_s;
    logic                    enter_pre_s;
    logic                    run_full_s;
    logic                    wrap_s;
    logic [ADDR_WIDTH-1:0]   wr_ptr_inc_s;
    logic [ADDR_WIDTH-1:0]   post_inc_s;
    logic [ADDR_WIDTH-1:0]   rd_start_s;
    logic [ADDR_WIDTH-1:0]   rd_inc_s;
    logic [ADDR_WIDTH-1:0]   last_addr_s;

    assign start_edge_s = bus.start & ~start_q_r;
    assign run_full_s   = (run_len_r == RUN_MAX);
    assign wrap_s       = (wr_ptr_r == ADDR_MAX);
    assign wr_ptr_inc_s = wr_ptr_r + ADDR_ONE;
    assign post_inc_s   = post_cnt_r + ADDR_ONE;
    assign rd_inc_s     = rd_addr_r + ADDR_ONE;
    assign last_addr_s  = wr_ptr_r - ADDR_ONE;
    // DONE is only ever entered on a write, so the oldest packet follows from post-write pointers.
    assign rd_start_s   = (wrapped_r | wrap_s) ? wr_ptr_inc_s : ADDR_ZERO;

    // Next-state decode plus the write/trigger-accept decision for this cycle.
    always_comb begin
        state_next_s = state_r;
        write_s      = 1'b0;
        accept_s     = 1'b0;
        enter_pre_s  = 1'b0;
        if (bus.abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_edge_s) begin
                        state_next_s = ST_PRE;
                        enter_pre_s  = 1'b1;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_PRE: begin
                    accept_s = bus.triggered & (pkt_cnt_r >= bus.pre_depth);
                    write_s  = first_r | bus.transition | run_full_s | accept_s;
                    if (accept_s) begin
                        state_next_s = (bus.post_depth == ADDR_ZERO) ? ST_DONE : ST_POST;
                    end else begin
                        state_next_s = ST_PRE;
                    end
                end
                ST_POST: begin
                    write_s = bus.transition | run_full_s;
                    // Stop on the requested depth, or before the trigger packet would be overwritten.
                    if (write_s && ((post_inc_s == bus.post_depth) || (wr_ptr_inc_s == trig_addr_r))) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_POST;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register, write pointer, counters and the registered RAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            start_q_r   <= 1'b0;
            wr_ptr_r    <= ADDR_ZERO;
            pkt_cnt_r   <= ADDR_ZERO;
            post_cnt_r  <= ADDR_ZERO;
            trig_addr_r <= ADDR_ZERO;
            run_len_r   <= 7'd0;
            wrapped_r   <= 1'b0;
            first_r     <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_waddr_r <= ADDR_ZERO;
            mem_wdata_r <= {PACKET_WIDTH{1'b0}};
        end else begin
            state_r   <= state_next_s;
            start_q_r <= bus.start;
            mem_we_r  <= write_s;
            if (write_s) begin
                mem_waddr_r <= wr_ptr_r;
                mem_wdata_r <= {accept_s, run_len_r, bus.latest_sample};
            end
            if (enter_pre_s) begin
                wr_ptr_r  <= ADDR_ZERO;
                pkt_cnt_r <= ADDR_ZERO;
                run_len_r <= 7'd0;
                wrapped_r <= 1'b0;
                first_r   <= 1'b1;
            end else if (write_s) begin
                wr_ptr_r  <= wr_ptr_inc_s;
                wrapped_r <= wrapped_r | wrap_s;
                run_len_r <= 7'd0;
                first_r   <= 1'b0;
                if ((state_r == ST_PRE) && (pkt_cnt_r != ADDR_MAX)) begin
                    pkt_cnt_r <= pkt_cnt_r + ADDR_ONE;
                end
                if (accept_s) begin
                    trig_addr_r <= wr_ptr_r;
                    post_cnt_r  <= ADDR_ZERO;
                end else if (state_r == ST_POST) begin
                    post_cnt_r <= post_inc_s;
                end
            end else if (!bus.abort && ((state_r == ST_PRE) || (state_r == ST_POST))) begin
                run_len_r <= run_len_r + 7'd1;
            end
        end
    end

    // Readout pointer and one-hot state flags, all registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_r   <= ADDR_ZERO;
            rd_last_r   <= 1'b0;
            idle_r      <= 1'b1;
            running_r   <= 1'b0;
            post_trig_r <= 1'b0;
            complete_r  <= 1'b0;
        end else begin
            idle_r      <= (state_next_s == ST_IDLE);
            running_r   <= (state_next_s == ST_PRE);
            post_trig_r <= (state_next_s == ST_POST);
            complete_r  <= (state_next_s == ST_DONE);
            if (state_next_s != ST_DONE) begin
                rd_addr_r <= ADDR_ZERO;
                rd_last_r <= 1'b0;
            end else if (state_r != ST_DONE) begin
                rd_addr_r <= rd_start_s;
                rd_last_r <= (rd_start_s == wr_ptr_r);
            end else if (bus.rd_next && !rd_last_r) begin
                rd_addr_r <= rd_inc_s;
                rd_last_r <= (rd_inc_s == last_addr_s);
            end
        end
    end

    assign bus.mem_we    = mem_we_r;
    assign bus.mem_waddr = mem_waddr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.rd_last   = rd_last_r;
    assign bus.idle      = idle_r;
    assign bus.running   = running_r;
    assign bus.post_trig = post_trig_r;
    assign bus.complete  = complete_r;
    assign bus.wrapped   = wrapped_r;
    assign bus.trig_addr = trig_addr_r;
endmodule

// File: tb/tb_capture_sequencer.sv
// Directed-plus-random bench for capture_sequencer with a 16-deep RAM, checked every cycle
// against a write-count based reference model.
module tb_capture_sequencer;
    localparam int SW     = 8;
    localparam int AW     = 4;
    localparam int PW     = 16;
    localparam int DEPTH  = 16;
    localparam int P_IDLE = 0;
    localparam int P_PRE  = 1;
    localparam int P_POST = 2;
    localparam int P_DONE = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    capture_sequencer_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .PACKET_WIDTH(PW)) bus ();

    capture_sequencer #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .PACKET_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase, total writes this capture, history count, run length, readout index.
    int m_ph = P_IDLE, m_total = 0, m_cnt = 0, m_run = 0, m_tad = 0, m_post = 0, m_rdi = 0;
    bit m_first = 1'b0, m_pstart = 1'b0, e_we = 1'b0;
    int e_waddr = 0;
    logic [PW-1:0] e_wdata = '0;
    logic [SW-1:0] last_sample = '0;
    logic [PW-1:0] obs_pk[$];
    int            obs_ad[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit edge_s, acc, wr;
        int addr;
        e_we = 1'b0;
        if (reset) begin
            m_ph = P_IDLE; m_total = 0; m_cnt = 0; m_run = 0; m_first = 1'b0;
            m_tad = 0; m_post = 0; m_rdi = 0; m_pstart = 1'b0;
            return;
        end
        edge_s   = bus.start && !m_pstart;
        m_pstart = bus.start;
        if (bus.abort) begin
            m_ph = P_IDLE; m_rdi = 0;
            return;
        end
        if (m_ph == P_IDLE || m_ph == P_DONE) begin
            if (edge_s) begin
                m_ph = P_PRE; m_total = 0; m_cnt = 0; m_run = 0; m_first = 1'b1; m_rdi = 0;
            end else if (m_ph == P_DONE && bus.rd_next &&
                         m_rdi < ((m_total >= DEPTH) ? DEPTH : m_total) - 1) begin
                m_rdi++;
            end
            return;
        end
        acc = (m_ph == P_PRE) && bus.triggered && (m_cnt >= int'(bus.pre_depth));
        wr  = m_first || bus.transition || (m_run == 127) || acc;
        if (!wr) begin
            m_run++;
            return;
        end
        addr    = m_total % DEPTH;
        e_we    = 1'b1;
        e_waddr = addr;
        e_wdata = {acc, 7'(m_run), bus.latest_sample};
        m_total++; m_run = 0; m_first = 1'b0;
        if (m_ph == P_PRE) m_cnt = (m_cnt + 1 > DEPTH - 1) ? DEPTH - 1 : m_cnt + 1;
        if (acc) begin
            m_tad = addr; m_post = 0; m_rdi = 0;
            m_ph  = (bus.post_depth == 4'd0) ? P_DONE : P_POST;
        end else if (m_ph == P_POST) begin
            m_post++;
            if (m_post == int'(bus.post_depth) || (m_total % DEPTH) == m_tad) begin
                m_ph = P_DONE; m_rdi = 0;
            end
        end
    endtask

    task automatic tick();
        int oldest, npk;
        @(posedge clk);
        model_update();
        #1;
        npk    = (m_total >= DEPTH) ? DEPTH : m_total;
        oldest = (m_total >= DEPTH) ? m_total % DEPTH : 0;
        chk("idle",      32'(bus.idle),      32'(m_ph == P_IDLE));
        chk("running",   32'(bus.running),   32'(m_ph == P_PRE));
        chk("post_trig", 32'(bus.post_trig), 32'(m_ph == P_POST));
        chk("complete",  32'(bus.complete),  32'(m_ph == P_DONE));
        chk("mem_we",    32'(bus.mem_we),    32'(e_we));
        if (e_we) begin
            chk("mem_waddr", 32'(bus.mem_waddr), 32'(e_waddr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        end
        chk("wrapped",   32'(bus.wrapped),   32'(m_total >= DEPTH));
        chk("trig_addr", 32'(bus.trig_addr), 32'(m_tad));
        chk("rd_addr",   32'(bus.rd_addr),   32'((m_ph == P_DONE) ? (oldest + m_rdi) % DEPTH : 0));
        chk("rd_last",   32'(bus.rd_last),   32'((m_ph == P_DONE) && (m_rdi == npk - 1)));
        if (bus.mem_we === 1'b1) begin
            obs_pk.push_back(bus.mem_wdata);
            obs_ad.push_back(int'(bus.mem_waddr));
        end
        @(negedge clk);
    endtask

    task automatic step(input bit st, input bit ab, input bit tr, input bit rn, input logic [SW-1:0] smp);
        bus.start         = st;
        bus.abort         = ab;
        bus.triggered     = tr;
        bus.rd_next       = rn;
        bus.transition    = (smp != last_sample);
        bus.latest_sample = smp;
        last_sample       = smp;
        tick();
    endtask

    function automatic logic [SW-1:0] diff_sample();
        logic [SW-1:0] flip;
        flip = SW'($urandom_range(1, 255));
        return last_sample ^ flip;
    endfunction

    initial begin
        int tidx, post_w, ovw, guard;
        logic [15:0] visited;
        bus.start = 1'b0; bus.abort = 1'b0; bus.triggered = 1'b0; bus.rd_next = 1'b0;
        bus.transition = 1'b0; bus.latest_sample = '0; bus.pre_depth = '0; bus.post_depth = '0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Constant sample: run-length saturation gives packets 0,127,127
        bus.pre_depth = 4'd15; bus.post_depth = 4'd3;
        obs_pk.delete(); obs_ad.delete();
        for (int c = 0; c < 301; c++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("s1_count", 32'(obs_pk.size()), 32'd3);
        if (obs_pk.size() == 3) begin
            chk("s1_pk0", 32'(obs_pk[0]), 32'h0000);
            chk("s1_pk1", 32'(obs_pk[1]), 32'h7F00);
            chk("s1_pk2", 32'(obs_pk[2]), 32'h7F00);
        end
        chk("s1_running", 32'(bus.running), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Trigger before pre_depth is ignored; later one accepted, 3 post packets
        bus.pre_depth = 4'd4; bus.post_depth = 4'd3;
        obs_pk.delete(); obs_ad.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, diff_sample());
        for (int c = 0; c < 15; c++) step(1'b0, 1'b0, (c == 2 || c == 6), 1'b0, diff_sample());
        chk("s2_count", 32'(obs_pk.size()), 32'd10);
        foreach (obs_pk[i]) chk("s2_trig_flag", 32'(obs_pk[i][PW-1]), 32'(i == 6));
        chk("s2_complete", 32'(bus.complete), 32'd1);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), last_sample);

        // Wrapped buffer: readout starts at wr_ptr and visits all 16 addresses
        bus.pre_depth = 4'd2; bus.post_depth = 4'd2;
        step(1'b0, 1'b0, 1'b0, 1'b0, last_sample);
        step(1'b1, 1'b0, 1'b0, 1'b0, diff_sample());
        for (int c = 0; c < 23; c++) step(1'b0, 1'b0, (c == 20), 1'b0, diff_sample());
        step(1'b0, 1'b0, 1'b0, 1'b0, last_sample);
        chk("s3_wrapped", 32'(bus.wrapped), 32'd1);
        chk("s3_trig_addr", 32'(bus.trig_addr), 32'd4);
        chk("s3_rd_start", 32'(bus.rd_addr), 32'd7);
        visited = 16'h0001 << bus.rd_addr;
        for (int p = 1; p <= 16; p++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, last_sample);
            visited = visited | (16'h0001 << bus.rd_addr);
            chk("s3_rd_last", 32'(bus.rd_last), 32'(p >= 15));
        end
        chk("s3_visited", 32'(visited), 32'h0000FFFF);
        chk("s3_rd_end", 32'(bus.rd_addr), 32'd6);

        // Max post depth: stops when full, trigger packet kept and oldest
        bus.pre_depth = 4'd1; bus.post_depth = 4'd15;
        step(1'b0, 1'b0, 1'b0, 1'b0, last_sample);
        obs_pk.delete(); obs_ad.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, last_sample);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0, 1'b0, SW'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b1, 1'b0, diff_sample());
        guard = 0;
        while (!bus.complete && guard < 3000) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                 ($urandom_range(0, 3) == 0) ? last_sample : diff_sample());
            guard++;
        end
        chk("s4_complete", 32'(bus.complete), 32'd1);
        chk("s4_wrapped", 32'(bus.wrapped), 32'd1);
        tidx = -1;
        foreach (obs_pk[i]) if (obs_pk[i][PW-1] && tidx < 0) tidx = i;
        chk("s4_trig_seen", 32'(tidx >= 0), 32'd1);
        post_w = 0; ovw = 0;
        if (tidx >= 0) begin
            foreach (obs_pk[i]) begin
                if (i > tidx) begin
                    post_w++;
                    if (obs_ad[i] == obs_ad[tidx]) ovw++;
                end
            end
        end
        chk("s4_post_writes", 32'(post_w), 32'd15);
        chk("s4_overwrite", 32'(ovw), 32'd0);
        chk("s4_oldest", 32'(bus.rd_addr), 32'(m_tad));

        // Abort in POST together with trigger and start edge
        bus.pre_depth = 4'd0; bus.post_depth = 4'd10;
        step(1'b0, 1'b0, 1'b0, 1'b0, last_sample);
        step(1'b1, 1'b0, 1'b0, 1'b0, diff_sample());
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, (c == 3), 1'b0, diff_sample());
        chk("s5_in_post", 32'(bus.post_trig), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, diff_sample());
        chk("s5_idle", 32'(bus.idle), 32'd1);
        obs_pk.delete(); obs_ad.delete();
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, diff_sample());
        chk("s5_no_writes", 32'(obs_pk.size()), 32'd0);
        chk("s5_still_idle", 32'(bus.idle), 32'd1);

        // Reset in POST, then a fresh capture
        bus.pre_depth = 4'd0; bus.post_depth = 4'd8;
        step(1'b1, 1'b0, 1'b0, 1'b0, diff_sample());
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, (c == 2), 1'b0, diff_sample());
        chk("s6_in_post", 32'(bus.post_trig), 32'd1);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, diff_sample());
        reset = 1'b0;
        chk("s6_idle", 32'(bus.idle), 32'd1);
        chk("s6_post_trig", 32'(bus.post_trig), 32'd0);
        chk("s6_we", 32'(bus.mem_we), 32'd0);
        chk("s6_trig_addr", 32'(bus.trig_addr), 32'd0);
        chk("s6_waddr", 32'(bus.mem_waddr), 32'd0);
        obs_pk.delete(); obs_ad.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, diff_sample());
        guard = 0;
        while (!bus.complete && guard < 2000) begin
            step(1'b0, 1'b0, (guard == 3), 1'b0, ($urandom_range(0, 2) == 0) ? last_sample : diff_sample());
            guard++;
        end
        chk("s6_complete", 32'(bus.complete), 32'd1);
        chk("s6_writes", 32'(obs_pk.size()), 32'(m_total));
        step(1'b0, 1'b0, 1'b0, 1'b0, last_sample);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
